hilo_unit: RTL and testbench

//  HI/LO special-register unit. Sits directly downstream of the multiplier and divider. It

---
 rtl/hilo_unit_if.sv | 31 +++
 rtl/hilo_unit.sv | 99 +++++++++
 tb/tb_hilo_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_unit_if.sv
// Pipeline <-> HI/LO unit bus: start strobes, upstream results, MT/MF requests and status.
interface hilo_unit_if;
    logic        mul_start;
    logic [63:0] mul_z;
    logic        div_start;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        mfhi;
    logic        mflo;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    modport master (
        output mul_start, mul_z, div_start, div_q, div_r,
               mthi, mtlo, wdata, mfhi, mflo,
        input  rdata, hi, lo, busy, stall, done
    );

    modport slave (
        input  mul_start, mul_z, div_start, div_q, div_r,
               mthi, mtlo, wdata, mfhi, mflo,
        output rdata, hi, lo, busy, stall, done
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: waits out multiplier/divider latency, captures results into HI/LO,
// serves MTHI/MTLO/MFHI/MFLO and stalls requests while a result is pending.
module hilo_unit #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 33
) (
    input  logic        clk,
    input  logic        reset,
    hilo_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_t;

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        any_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A start wins over MT writes issued in the same cycle.
                if (bus.mul_start) begin
                    state_d = MUL_BUSY;
                    cnt_d   = MUL_CNT;
                end else if (bus.div_start) begin
                    state_d = DIV_BUSY;
                    cnt_d   = DIV_CNT;
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            MUL_BUSY: begin
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    hi_d    = bus.mul_z[63:32];
                    lo_d    = bus.mul_z[31:0];
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            DIV_BUSY: begin
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    hi_d    = bus.div_r;
                    lo_d    = bus.div_q;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign any_req   = bus.mul_start | bus.div_start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo;
    assign bus.busy  = (state_q != IDLE);
    assign bus.stall = bus.busy & any_req;
    assign bus.rdata = bus.mfhi ? hi_q : (bus.mflo ? lo_q : '0);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed scenarios plus random traffic, every cycle compared against a
// transaction-level model that tracks the absolute edge at which a pending result lands.
module tb_hilo_unit;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;

    logic clk;
    logic reset;
    hilo_unit_if bus();

    hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: register contents, pending result landing edge (-1 = none), result kind.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_done = 1'b0;
    int          m_cap_edge = -1;
    bit          m_is_mul = 1'b0;
    int          edge_n = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_done = 1'b0;
            m_cap_edge = -1;
        end else if (m_cap_edge >= 0) begin
            m_done = 1'b0;
            if (edge_n == m_cap_edge) begin
                if (m_is_mul) {m_hi, m_lo} = bus.mul_z;
                else begin
                    m_hi = bus.div_r;
                    m_lo = bus.div_q;
                end
                m_done = 1'b1;
                m_cap_edge = -1;
            end
        end else begin
            m_done = 1'b0;
            if (bus.mul_start) begin
                m_is_mul = 1'b1;
                m_cap_edge = edge_n + MUL_LAT;
            end else if (bus.div_start) begin
                m_is_mul = 1'b0;
                m_cap_edge = edge_n + DIV_LAT;
            end else begin
                if (bus.mthi) m_hi = bus.wdata;
                if (bus.mtlo) m_lo = bus.wdata;
            end
        end
        edge_n++;
    endtask

    // Entered just after a negedge with inputs already driven; returns at the next negedge.
    task automatic tick(input bit do_chk);
        logic        m_busy;
        logic        any_req;
        logic [31:0] exp_rd;
        #1;
        if (do_chk) begin
            m_busy  = (m_cap_edge >= 0);
            any_req = bus.mul_start | bus.div_start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo;
            exp_rd  = bus.mfhi ? m_hi : (bus.mflo ? m_lo : 32'h0);
            chk("busy",  64'(bus.busy),  64'(m_busy));
            chk("stall", 64'(bus.stall), 64'(m_busy & any_req));
            chk("done",  64'(bus.done),  64'(m_done));
            chk("hi",    64'(bus.hi),    64'(m_hi));
            chk("lo",    64'(bus.lo),    64'(m_lo));
            chk("rdata", 64'(bus.rdata), 64'(exp_rd));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        bus.mul_start = 1'b0;
        bus.div_start = 1'b0;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        bus.mfhi = 1'b0;
        bus.mflo = 1'b0;
    endtask

    initial begin
        int r;
        reset = 1'b1;
        clear_reqs();
        bus.mul_z = '0;
        bus.div_q = '0;
        bus.div_r = '0;
        bus.wdata = '0;
        @(negedge clk);
        tick(1'b0);

        // Reset state, with an MF request showing rdata stays 0
        bus.mfhi = 1'b1;
        #1;
        chk("rst_hi", 64'(bus.hi), 64'h0);
        chk("rst_lo", 64'(bus.lo), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_stall", 64'(bus.stall), 64'h0);
        chk("rst_done", 64'(bus.done), 64'h0);
        chk("rst_rdata", 64'(bus.rdata), 64'h0);
        tick(1'b1);
        reset = 1'b0;
        clear_reqs();
        tick(1'b1);

        // Multiply with fixed product
        bus.mul_z = 64'h0000_0001_FFFF_FFFE;
        bus.mul_start = 1'b1;
        tick(1'b1);
        bus.mul_start = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) tick(1'b1);
        chk("t1_hi", 64'(bus.hi), 64'h1);
        chk("t1_lo", 64'(bus.lo), 64'hFFFF_FFFE);
        chk("t1_done", 64'(bus.done), 64'h1);
        chk("t1_busy", 64'(bus.busy), 64'h0);

        // Back-to-back multiply issued in the done cycle
        bus.mul_z = {$urandom(), $urandom()};
        bus.mul_start = 1'b1;
        #1;
        chk("t6_stall", 64'(bus.stall), 64'h0);
        tick(1'b1);
        bus.mul_start = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) tick(1'b1);
        chk("t6_hilo", {32'(bus.hi), 32'(bus.lo)}, bus.mul_z);

        // Divide with an MFHI held (stalled) through the busy window, then retried
        bus.div_q = 32'd7;
        bus.div_r = 32'd3;
        bus.div_start = 1'b1;
        tick(1'b1);
        bus.div_start = 1'b0;
        bus.mfhi = 1'b1;
        #1;
        chk("t2_stall", 64'(bus.stall), 64'h1);
        for (int i = 0; i < 100 && m_cap_edge >= 0; i++) tick(1'b1);
        chk("t2_hi", 64'(bus.hi), 64'h3);
        chk("t2_lo", 64'(bus.lo), 64'h7);
        chk("t2_rdata", 64'(bus.rdata), 64'h3);
        chk("t2_stall_off", 64'(bus.stall), 64'h0);
        bus.mfhi = 1'b0;
        tick(1'b1);

        // MTHI then MFLO then MFHI
        bus.mthi = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        tick(1'b1);
        bus.mthi = 1'b0;
        bus.mflo = 1'b1;
        tick(1'b1);
        bus.mflo = 1'b0;
        bus.mfhi = 1'b1;
        #1;
        chk("t3_rdata", 64'(bus.rdata), 64'hA5A5_A5A5);
        chk("t3_lo", 64'(bus.lo), 64'h7);
        tick(1'b1);
        clear_reqs();

        // mul_start with MTLO in the same cycle: MTLO dropped
        bus.mul_z = 64'h1234_5678_9ABC_DEF0;
        bus.mul_start = 1'b1;
        bus.mtlo = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        tick(1'b1);
        clear_reqs();
        chk("t4_lo_kept", 64'(bus.lo), 64'h7);
        for (int i = 0; i < MUL_LAT; i++) tick(1'b1);
        chk("t4_lo", 64'(bus.lo), 64'h9ABC_DEF0);

        // Reset two cycles before a multiply would land
        bus.mul_start = 1'b1;
        tick(1'b1);
        bus.mul_start = 1'b0;
        tick(1'b1);
        reset = 1'b1;
        tick(1'b1);
        reset = 1'b0;
        chk("t5_hi", 64'(bus.hi), 64'h0);
        chk("t5_lo", 64'(bus.lo), 64'h0);
        chk("t5_busy", 64'(bus.busy), 64'h0);
        for (int i = 0; i < MUL_LAT + 2; i++) tick(1'b1);

        // Random traffic; operands only change while nothing is pending
        for (int i = 0; i < 600; i++) begin
            if (m_cap_edge < 0) begin
                bus.mul_z = {$urandom(), $urandom()};
                bus.div_q = $urandom();
                bus.div_r = $urandom();
            end
            r = int'($urandom_range(0, 99));
            bus.mul_start = (r < 6) || (r >= 95);
            bus.div_start = (r >= 6 && r < 10) || (r >= 95);
            bus.mthi = ($urandom_range(0, 3) == 0);
            bus.mtlo = ($urandom_range(0, 3) == 0);
            bus.mfhi = ($urandom_range(0, 3) == 0);
            bus.mflo = ($urandom_range(0, 3) == 0);
            bus.wdata = $urandom();
            reset = ($urandom_range(0, 149) == 0);
            tick(1'b1);
        end
        reset = 1'b0;
        clear_reqs();
        tick(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
